// File: rtl/mem_access_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mem_lsu_pkg                                                  |
// | Purpose  : Shared types and constants for the load/store unit: RV32     |
// |            funct3 size/sign codes, response error codes, FSM states.    |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_lsu_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mem_access_lsu_if                                            |
// | Purpose  : Request/response bundle between execute and the LSU.         |
// | Ports    : req_valid/req_ready handshake, mem_read, mem_write, funct3,  |
// |            addr, wdata (request); resp_valid, rdata, err (response).    |
// |            master = requester side, slave = LSU side.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface mem_access_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            resp_valid;
  logic [XLEN-1:0] rdata;
  logic [1:0]      err;

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_lsu_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : lsu_lane_align                                               |
// | Purpose  : Combinational byte-lane steering for the LSU.                |
// | Ports    : is_load, is_store, funct3, lane (addr[1:0]), wdata, raw      |
// |            (in); be, wdata_lane, ldata, misalign, illegal (out).        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module lsu_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] ldata,
  output logic            misalign,
  output logic            illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = raw[{lane, 3'b000} +: 8];
  assign w_half = raw[{lane[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = '0;
    ldata      = '0;
    misalign   = 1'b0;
    illegal    = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B:    ldata = {{(XLEN-8){w_byte[7]}}, w_byte};
        F3_BU:   ldata = {{(XLEN-8){1'b0}}, w_byte};
        F3_H: begin
          ldata    = {{(XLEN-16){w_half[15]}}, w_half};
          misalign = lane[0];
        end
        F3_HU: begin
          ldata    = {{(XLEN-16){1'b0}}, w_half};
          misalign = lane[0];
        end
        F3_W: begin
          ldata    = raw;
          misalign = |lane;
        end
        default: illegal = 1'b1;
      endcase
    end else if (is_store) begin
      // Data is replicated across lanes; the byte enable picks the target lane.
      if (funct3[2]) begin
        illegal = 1'b1;
      end else begin
        case (funct3[1:0])
          2'b00: begin
            be         = 4'b0001 << lane;
            wdata_lane = {(XLEN/8){wdata[7:0]}};
          end
          2'b01: begin
            be         = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {(XLEN/16){wdata[15:0]}};
            misalign   = lane[0];
          end
          default: begin
            be         = 4'b1111;
            wdata_lane = wdata;
            misalign   = |lane;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mem_access_lsu                                               |
// | Purpose  : Byte-addressed RV32 load/store unit over a word RAM with a   |
// |            valid/ready request, fixed access latency and error codes.   |
// | Ports    : clk, rst_n (async active-low), bus (mem_access_lsu_if.slave) |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mem_access_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_lsu_if.slave    bus
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t          r_state, w_state_nxt;
  logic            r_live;
  logic [CW-1:0]   r_cnt;
  logic            r_rd, r_wr;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_rdata;
  logic [1:0]      r_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_accept, w_commit, w_is_store, w_range_bad;
  logic            w_misalign, w_illegal;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wlane, w_ldata, w_raw;
  err_t            w_err;

  // Ready only rises on the first clock after reset release.
  assign bus.req_ready  = r_live && (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;

  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_commit    = (r_state == ACCESS) && (r_cnt == '0);
  assign w_is_store  = r_wr && !r_rd;           // read wins when both set
  assign w_idx       = r_addr[AW+1:2];
  assign w_range_bad = |r_addr[XLEN-1:AW+2];
  assign w_raw       = r_mem[w_idx];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .is_load    (r_rd),
    .is_store   (w_is_store),
    .funct3     (r_f3),
    .lane       (r_addr[1:0]),
    .wdata      (r_wdata),
    .raw        (w_raw),
    .be         (w_be),
    .wdata_lane (w_wlane),
    .ldata      (w_ldata),
    .misalign   (w_misalign),
    .illegal    (w_illegal)
  );

  // Priority: illegal > misaligned > range; a no-op never reports range.
  always_comb begin
    w_err = ERR_NONE;
    if (w_illegal)                        w_err = ERR_ILLEGAL;
    else if (w_misalign)                  w_err = ERR_MISALIGN;
    else if ((r_rd || r_wr) && w_range_bad) w_err = ERR_RANGE;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_state_nxt = ACCESS;
      ACCESS:  if (r_cnt == '0)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_rd    <= bus.mem_read;
        r_wr    <= bus.mem_write;
        r_f3    <= bus.funct3;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= ERR_NONE;
    end else begin
      r_resp_valid <= w_commit;
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (r_rd && (w_err == ERR_NONE)) ? w_ldata : '0;
      end
    end
  end

  // RAM has no reset; the commit qualifier is itself held off by reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_is_store && (w_err == ERR_NONE)) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mem_access_lsu                                            |
// | Purpose  : Self-checking bench for mem_access_lsu at LATENCY 1 and 3.   |
// | Ports    : none                                                        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_access_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_lsu_if #(.XLEN(32)) bus1 ();
  mem_access_lsu_if #(.XLEN(32)) bus3 ();

  mem_access_lsu #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_access_lsu #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic rd; logic wr; logic [2:0] f3;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic [1:0] err;
  } vec_t;
  typedef struct { logic [31:0] rdata; logic [1:0] err; int lat; } exp_t;

  exp_t sb[$];

  function automatic logic ready_of(input bit l3);
    return l3 ? bus3.req_ready : bus1.req_ready;
  endfunction
  function automatic logic resp_of(input bit l3);
    return l3 ? bus3.resp_valid : bus1.resp_valid;
  endfunction
  function automatic logic [31:0] rdata_of(input bit l3);
    return l3 ? bus3.rdata : bus1.rdata;
  endfunction
  function automatic logic [1:0] err_of(input bit l3);
    return l3 ? bus3.err : bus1.err;
  endfunction

  task automatic drive_bus(input bit l3, input logic v, input vec_t t);
    if (l3) begin
      bus3.req_valid = v; bus3.mem_read = t.rd; bus3.mem_write = t.wr;
      bus3.funct3 = t.f3; bus3.addr = t.addr; bus3.wdata = t.wdata;
    end else begin
      bus1.req_valid = v; bus1.mem_read = t.rd; bus1.mem_write = t.wr;
      bus1.funct3 = t.f3; bus1.addr = t.addr; bus1.wdata = t.wdata;
    end
  endtask

  // Presents a request, pushes its expectation, returns at the negedge after the accept edge.
  task automatic issue(input bit l3, input vec_t t, input bit expect_resp,
                       output int t0, output bit to);
    exp_t e;
    to = 1'b1;
    @(negedge clk);
    drive_bus(l3, 1'b1, t);
    if (expect_resp) begin
      e.rdata = t.rdata; e.err = t.err; e.lat = l3 ? 3 : 1;
      sb.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      if (ready_of(l3)) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    drive_bus(l3, 1'b0, t);
  endtask

  task automatic collect(input bit l3, input int t0, output logic [31:0] rd,
                         output logic [1:0] er, output int lat, output bit to);
    to = 1'b1; rd = '0; er = '0; lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (resp_of(l3)) begin
        rd = rdata_of(l3); er = err_of(l3); lat = cyc - t0; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int l = 0; l < 2; l++) begin
      vectors++;
      if (ready_of(l == 1) !== 1'b0) begin miscompares++;
        $display("FAIL reset_ready L%0d: got %b want 0", l, ready_of(l == 1)); end
      vectors++;
      if (resp_of(l == 1) !== 1'b0) begin miscompares++;
        $display("FAIL reset_resp_valid L%0d: got %b want 0", l, resp_of(l == 1)); end
      vectors++;
      if (rdata_of(l == 1) !== 32'h0) begin miscompares++;
        $display("FAIL reset_rdata L%0d: got %h want 0", l, rdata_of(l == 1)); end
      vectors++;
      if (err_of(l == 1) !== 2'b00) begin miscompares++;
        $display("FAIL reset_err L%0d: got %b want 00", l, err_of(l == 1)); end
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus1.req_ready !== 1'b0) begin miscompares++;
      $display("FAIL ready_before_clk: got %b want 0", bus1.req_ready); end
    @(negedge clk);
    vectors++;
    if (bus1.req_ready !== 1'b1) begin miscompares++;
      $display("FAIL ready_after_clk: got %b want 1", bus1.req_ready); end
  endtask

  task automatic test_store_load;
    vec_t t[$]; exp_t e; int t0, lat; bit to1, to2; logic [31:0] rd; logic [1:0] er;
    t.push_back('{1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 2'b00});
    t.push_back('{1'b0, 1'b1, F3_B,  32'h11, 32'h12345655, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 2'b00});
    t.push_back('{1'b0, 1'b1, F3_H,  32'h12, 32'h0000CAFE, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b0, F3_W,  32'h10, 32'h0,        32'hCAFE55EF, 2'b00});
    foreach (t[i]) begin
      issue(1'b0, t[i], 1'b1, t0, to1);
      vectors++;
      if (bus1.req_ready !== 1'b0) begin miscompares++;
        $display("FAIL sl_ready_low[%0d]: got %b want 0", i, bus1.req_ready); end
      collect(1'b0, t0, rd, er, lat, to2);
      e = sb.pop_front();
      vectors++;
      if (to1 || to2) begin miscompares++;
        $display("FAIL sl_timeout[%0d]: got no response want resp_valid", i);
      end else begin
        vectors++;
        if (rd !== e.rdata) begin miscompares++;
          $display("FAIL sl_rdata[%0d]: got %h want %h", i, rd, e.rdata); end
        vectors++;
        if (er !== e.err) begin miscompares++;
          $display("FAIL sl_err[%0d]: got %b want %b", i, er, e.err); end
        vectors++;
        if (lat !== e.lat) begin miscompares++;
          $display("FAIL sl_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
        vectors++;
        if (bus1.req_ready !== 1'b1) begin miscompares++;
          $display("FAIL sl_ready_back[%0d]: got %b want 1", i, bus1.req_ready); end
      end
    end
  endtask

  task automatic test_errors;
    vec_t t[$]; exp_t e; int t0, lat; bit to1, to2; logic [31:0] rd; logic [1:0] er;
    t.push_back('{1'b0, 1'b1, F3_W,   32'h20,  32'hA5A5A5A5, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b0, F3_W,   32'h12,  32'h0,        32'h0,        2'b01});
    t.push_back('{1'b0, 1'b1, F3_H,   32'h21,  32'h0000FFFF, 32'h0,        2'b01});
    t.push_back('{1'b1, 1'b0, F3_W,   32'h20,  32'h0,        32'hA5A5A5A5, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_W,   32'h400, 32'h0,        32'h0,        2'b10});
    t.push_back('{1'b1, 1'b0, F3_H,   32'h403, 32'h0,        32'h0,        2'b01});
    t.push_back('{1'b1, 1'b0, 3'b011, 32'h401, 32'h0,        32'h0,        2'b11});
    t.push_back('{1'b1, 1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        2'b11});
    t.push_back('{1'b0, 1'b1, 3'b100, 32'h20,  32'h0,        32'h0,        2'b11});
    t.push_back('{1'b0, 1'b1, F3_W,   32'h420, 32'h0,        32'h0,        2'b10});
    t.push_back('{1'b1, 1'b0, F3_W,   32'h20,  32'h0,        32'hA5A5A5A5, 2'b00});
    t.push_back('{1'b0, 1'b0, F3_W,   32'h401, 32'h0,        32'h0,        2'b00});
    foreach (t[i]) begin
      issue(1'b0, t[i], 1'b1, t0, to1);
      collect(1'b0, t0, rd, er, lat, to2);
      e = sb.pop_front();
      vectors++;
      if (to1 || to2) begin miscompares++;
        $display("FAIL err_timeout[%0d]: got no response want resp_valid", i);
      end else begin
        vectors++;
        if (rd !== e.rdata) begin miscompares++;
          $display("FAIL err_rdata[%0d]: got %h want %h", i, rd, e.rdata); end
        vectors++;
        if (er !== e.err) begin miscompares++;
          $display("FAIL err_code[%0d]: got %b want %b", i, er, e.err); end
        vectors++;
        if (lat !== e.lat) begin miscompares++;
          $display("FAIL err_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      end
    end
  endtask

  task automatic test_read_wins;
    vec_t t[$]; exp_t e; int t0, lat; bit to1, to2; logic [31:0] rd; logic [1:0] er;
    t.push_back('{1'b0, 1'b1, F3_W, 32'h40, 32'h12345678, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b1, F3_W, 32'h40, 32'hFFFFFFFF, 32'h12345678, 2'b00});
    t.push_back('{1'b1, 1'b0, F3_W, 32'h40, 32'h0,        32'h12345678, 2'b00});
    t.push_back('{1'b0, 1'b1, F3_W, 32'h50, 32'hCAFEF00D, 32'h0,        2'b00});
    t.push_back('{1'b1, 1'b0, F3_W, 32'h50, 32'h0,        32'hCAFEF00D, 2'b00});
    foreach (t[i]) begin
      issue(1'b1, t[i], 1'b1, t0, to1);
      collect(1'b1, t0, rd, er, lat, to2);
      e = sb.pop_front();
      vectors++;
      if (to1 || to2) begin miscompares++;
        $display("FAIL l3_timeout[%0d]: got no response want resp_valid", i);
      end else begin
        vectors++;
        if (rd !== e.rdata) begin miscompares++;
          $display("FAIL l3_rdata[%0d]: got %h want %h", i, rd, e.rdata); end
        vectors++;
        if (er !== e.err) begin miscompares++;
          $display("FAIL l3_err[%0d]: got %b want %b", i, er, e.err); end
        vectors++;
        if (lat !== e.lat) begin miscompares++;
          $display("FAIL l3_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      end
    end
  endtask

  // req_valid held through ACCESS: second accept at T0+4, pulses at T0+3 and T0+7.
  task automatic test_back_to_back;
    vec_t t; exp_t e; int t0; int offs[$]; logic [31:0] got[$]; logic rdy; logic rdy_exp;
    t = '{1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h12345678, 2'b00};
    @(negedge clk);
    drive_bus(1'b1, 1'b1, t);
    for (int k = 0; k < 2; k++) begin
      e.rdata = t.rdata; e.err = t.err; e.lat = 3; sb.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      if (bus3.req_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      rdy = bus3.req_ready;
      rdy_exp = (k == 3) || (k >= 7);
      vectors++;
      if (rdy !== rdy_exp) begin miscompares++;
        $display("FAIL b2b_ready[T0+%0d]: got %b want %b", k, rdy, rdy_exp); end
      if (bus3.resp_valid) begin offs.push_back(cyc - t0); got.push_back(bus3.rdata); end
      if (k == 4) drive_bus(1'b1, 1'b0, t);
      @(negedge clk);
    end
    vectors++;
    if (offs.size() != 2) begin miscompares++;
      $display("FAIL b2b_pulse_count: got %0d want 2", offs.size());
    end else begin
      vectors++;
      if (offs[0] != 3) begin miscompares++;
        $display("FAIL b2b_first_pulse: got T0+%0d want T0+3", offs[0]); end
      vectors++;
      if (offs[1] != 7) begin miscompares++;
        $display("FAIL b2b_second_pulse: got T0+%0d want T0+7", offs[1]); end
      for (int k = 0; k < 2; k++) begin
        e = sb.pop_front();
        vectors++;
        if (got[k] !== e.rdata) begin miscompares++;
          $display("FAIL b2b_rdata[%0d]: got %h want %h", k, got[k], e.rdata); end
      end
    end
    sb.delete();
  endtask

  task automatic test_reset_abort;
    vec_t t; exp_t e; int t0, lat, pulses; bit to1, to2; logic [31:0] rd; logic [1:0] er;
    t = '{1'b0, 1'b1, F3_W, 32'h50, 32'h11111111, 32'h0, 2'b00};
    issue(1'b1, t, 1'b0, t0, to1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus3.resp_valid) pulses++;
      if (k == 1) begin
        vectors++;
        if (bus3.req_ready !== 1'b0) begin miscompares++;
          $display("FAIL abort_ready: got %b want 0", bus3.req_ready); end
        vectors++;
        if (bus3.rdata !== 32'h0) begin miscompares++;
          $display("FAIL abort_rdata_cleared: got %h want 0", bus3.rdata); end
      end
      if (k == 3) rst_n = 1'b1;
    end
    vectors++;
    if (pulses != 0) begin miscompares++;
      $display("FAIL abort_resp_valid: got %0d pulses want 0", pulses); end
    t = '{1'b1, 1'b0, F3_W, 32'h50, 32'h0, 32'hCAFEF00D, 2'b00};
    issue(1'b1, t, 1'b1, t0, to1);
    collect(1'b1, t0, rd, er, lat, to2);
    e = sb.pop_front();
    vectors++;
    if (to1 || to2) begin miscompares++;
      $display("FAIL abort_reload_timeout: got no response want resp_valid");
    end else begin
      vectors++;
      if (rd !== e.rdata) begin miscompares++;
        $display("FAIL abort_ram_intact: got %h want %h", rd, e.rdata); end
    end
  endtask

  initial begin
    vec_t z;
    z = '{default: '0};
    rst_n = 1'b0;
    drive_bus(1'b0, 1'b0, z);
    drive_bus(1'b1, 1'b0, z);
    repeat (3) @(negedge clk);
    test_reset;
    test_store_load;
    test_errors;
    test_read_wins;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_lsu.md
Name: mem_access_lsu

Overview:
- Parametrised successor of the pipeline's data-memory access stage.
- Byte-addressed load/store unit over an internal word-organised data RAM.
- Supports RV32 LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane steering and sign/zero extension.
- Adds a valid/ready request handshake, configurable access latency, and alignment, range and illegal-op error reporting; sits between execute (ALU address) and writeback.

Parameters:
- XLEN, 32: data and address width.
- DEPTH_WORDS, 256: RAM depth in XLEN-bit words; must be a power of two and at least 2.
- LATENCY, 1: cycles from request acceptance to response; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  access size and sign (RV32 load/store encoding).
- addr  in  XLEN  byte address (ALU result).
- wdata  in  XLEN  store data (rs2).
- resp_valid  out  1  one-cycle response pulse.
- rdata  out  XLEN  load result, extended to XLEN.
- err  out  2  error code: 00 none, 01 misaligned, 10 out-of-range, 11 illegal funct3.

Behaviour:
- Reset (async, rst_n low): req_ready=0 while asserted and 1 from the first clk after release; resp_valid=0, rdata=0, err=00, FSM=IDLE, latency counter=0. RAM contents are not reset and are undefined until written.
- FSM IDLE:
  - req_ready=1.
  - On req_valid at a rising edge (accept edge T0), capture mem_read, mem_write, funct3, addr and wdata, load counter with LATENCY-1, go to ACCESS.
- FSM ACCESS:
  - req_ready=0.
  - Counter decrements each cycle.
  - At the edge where the counter is 0 (T0+LATENCY): commit the operation, register resp_valid=1 with rdata and err, return to IDLE.
  - Inputs are ignored while in ACCESS.
- Timing and throughput:
  - resp_valid is high for exactly one cycle, beginning at T0+LATENCY; cleared at the next edge.
  - rdata and err hold their values until the next response or reset.
  - The earliest next accept edge is T0+LATENCY+1, i.e. one transaction per LATENCY+1 cycles.
- Op select:
  - mem_read and mem_write both high: read wins and no write occurs.
  - Neither high: no-op; still responds with rdata=0, err=00.
- Word index is addr[AW+1:2] with AW=log2(DEPTH_WORDS). Byte lane is addr[1:0].
- Error priority (illegal > misaligned > range):
  - illegal: funct3 in {011,110,111} for a load, or funct3[2]=1 for a store.
  - misaligned: half access with addr[0]=1, or word access with addr[1:0]!=00.
  - range: addr[XLEN-1:AW+2] != 0.
  - On any error: no RAM write, rdata=0, resp_valid still pulses.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - The signed variants sign-extend; the U variants zero-extend.
- Stores:
  - SB writes wdata[7:0] into byte lane addr[1:0].
  - SH writes wdata[15:0] into half addr[1].
  - SW writes the full word.
  - Other lanes are unchanged (per-byte write enable).
  - rdata=0 on a store response.
- Reset asserted mid-ACCESS: the transaction is aborted, no RAM write occurs, and no response is produced.

Decomposition:
- Package mem_lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - err_t enum {ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL}.
  - state_t enum {IDLE, ACCESS}.
- One combinational sub-module, lsu_lane_align:
  - Store side: from funct3, addr[1:0] and wdata, produce the 4-bit byte enable and lane-shifted write data.
  - Load side: from funct3, addr[1:0] and the raw word, produce the extended load data.
  - Also outputs the misaligned and illegal flags.

Test Plan:
- LATENCY=1: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> resp_valid pulses at T0+1 each time, rdata=0xDEADBEEF, err=00; req_ready low exactly 1 cycle per request.
- After the above word: LB addr=0x13 -> 0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x10 -> 0x0000BEEF.
- SB addr=0x11 wdata=0x55, then LW addr=0x10 -> 0xDEAD55EF (other lanes intact).
- Error cases: LW addr=0x12 -> err=01; SH addr=0x21 -> err=01 and the word at 0x20 is unchanged; LW addr=0x400 with DEPTH_WORDS=256 -> err=10; load with funct3=011 -> err=11. All return rdata=0.
- LATENCY=3: accept at T0 -> resp_valid exactly at T0+3; req_valid held high during ACCESS is not re-accepted until T0+4; read+write both high -> read data returned and RAM unchanged.
- Drop rst_n at T0+1 of a LATENCY=3 SW -> no resp_valid; a later LW at the same address returns the pre-store contents.
